// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
//   mode_e    : run-time pattern select (FILL, RUN, BOUNCE, COUNT)
//   DIR_*     : BOUNCE travel direction
//   seed()    : reset/reload pattern for a mode, sized for up to 32 LEDs
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_FILL   = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Caller truncates the result to its own LED width.
  function automatic logic [31:0] seed(input mode_e m, input int unsigned n);
    logic [31:0] s;
    s = '0;
    case (m)
      MODE_FILL:   s = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
      MODE_RUN:    s = 32'd1;
      MODE_BOUNCE: s = 32'd1;
      MODE_COUNT:  s = '0;
      default:     s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Period counter: strobes tick_o for one cycle every TICK_CYCLES un-held cycles.
//   clk    : clock
//   rst    : synchronous active-high reset, counter to 0
//   clr    : synchronous clear, counter to 0
//   hold   : freeze the counter (tick_o forced low)
//   tick_o : combinational strobe, high while the counter sits at its last value
module tick_prescaler #(
  parameter int unsigned TICK_CYCLES = 13500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick_o
);

  localparam int unsigned CNT_W = $clog2(TICK_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign tick_o = w_last & ~hold;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (!hold) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: steps one of four patterns across N_LEDS outputs once
// every TICK_CYCLES clocks, with pause/single-step and tick/wrap status pulses.
//   clk   : clock
//   rst   : synchronous active-high reset
//   mode  : 0 FILL, 1 RUN, 2 BOUNCE, 3 COUNT
//   pause : hold prescaler and pattern while high
//   step  : single advance pulse, honoured only while paused
//   led   : registered LED drive
//   tick  : one-cycle pulse on each advance
//   wrap  : one-cycle pulse when a full sequence completes (implies tick)
// Build option: define LED_ACTIVE_LOW_EN to drive led = ~pattern.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int unsigned N_LEDS      = 6,
  parameter int unsigned TICK_CYCLES = 13500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              pause,
  input  logic              step,
  output logic [N_LEDS-1:0] led,
  output logic              tick,
  output logic              wrap
);

  logic [N_LEDS-1:0] r_pat;
  logic              r_dir;
  mode_e             r_mode;
  logic              r_tick;
  logic              r_wrap;

  logic              w_mode_chg;
  logic              w_pre_tick;
  logic              w_adv;
  logic [N_LEDS-1:0] w_nxt_pat;
  logic              w_nxt_dir;
  logic              w_nxt_wrap;

  assign w_mode_chg = (mode != r_mode);

  // A pending mode change wins over any advance in the same cycle.
  assign w_adv = ~w_mode_chg & (pause ? step : w_pre_tick);

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_mode_chg),
    .hold  (pause),
    .tick_o(w_pre_tick)
  );

  always_comb begin
    w_nxt_pat  = r_pat;
    w_nxt_dir  = r_dir;
    w_nxt_wrap = 1'b0;
    unique case (r_mode)
      MODE_FILL: begin
        if (r_pat == '0) begin
          w_nxt_pat  = '1;
          w_nxt_wrap = 1'b1;
        end else begin
          w_nxt_pat = r_pat << 1;
        end
      end
      MODE_RUN: begin
        w_nxt_pat  = {r_pat[N_LEDS-2:0], r_pat[N_LEDS-1]};
        w_nxt_wrap = r_pat[N_LEDS-1];
      end
      MODE_BOUNCE: begin
        if (r_dir == DIR_LEFT) begin
          w_nxt_pat = r_pat << 1;
          if (w_nxt_pat[N_LEDS-1]) w_nxt_dir = DIR_RIGHT;
        end else begin
          w_nxt_pat = r_pat >> 1;
          if (w_nxt_pat[0]) begin
            w_nxt_dir  = DIR_LEFT;
            w_nxt_wrap = 1'b1;
          end
        end
      end
      MODE_COUNT: begin
        w_nxt_pat  = r_pat + N_LEDS'(1);
        w_nxt_wrap = &r_pat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_mode_chg) begin
      r_mode <= mode_e'(mode);
      r_pat  <= N_LEDS'(seed(mode_e'(mode), N_LEDS));
      r_dir  <= DIR_LEFT;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_adv) begin
      r_pat  <= w_nxt_pat;
      r_dir  <= w_nxt_dir;
      r_tick <= 1'b1;
      r_wrap <= w_nxt_wrap;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~r_pat;
`else
  assign led = r_pat;
`endif
  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq: an index-based reference model pushes
// expected led/tick/wrap each cycle; the entry is popped after the edge.
module tb_led_pattern_seq;

  localparam int N  = 6;
  localparam int T  = 4;
  localparam int NC = 4;

`ifdef LED_ACTIVE_LOW_EN
  localparam bit ActLow = 1'b1;
`else
  localparam bit ActLow = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, pause, step;
  logic [1:0]    mode;
  logic [N-1:0]  led;
  logic          tick, wrap;

  logic          c_rst;
  logic [NC-1:0] c_led;
  logic          c_tick, c_wrap;

  led_pattern_seq #(
    .N_LEDS(N),
    .TICK_CYCLES(T)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .pause(pause),
    .step (step),
    .led  (led),
    .tick (tick),
    .wrap (wrap)
  );

  led_pattern_seq #(
    .N_LEDS(NC),
    .TICK_CYCLES(1)
  ) dut_c (
    .clk  (clk),
    .rst  (c_rst),
    .mode (2'd3),
    .pause(1'b0),
    .step (1'b0),
    .led  (c_led),
    .tick (c_tick),
    .wrap (c_wrap)
  );

  typedef struct {
    logic [31:0] led;
    logic        tick;
    logic        wrap;
  } exp_t;

  exp_t sb_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask_n(input int n);
    return (n >= 32) ? 32'hffff_ffff : ((32'd1 << n) - 32'd1);
  endfunction

  function automatic int seq_len(input int m, input int n);
    case (m)
      0:       return n + 1;
      1:       return n;
      2:       return 2 * (n - 1);
      default: return 1 << n;
    endcase
  endfunction

  // Pattern as a function of the step index within the sequence.
  function automatic logic [31:0] exp_pat(input int m, input int idx, input int n);
    int pos;
    case (m)
      0: return (idx >= n) ? 32'd0 : ((mask_n(n) << idx) & mask_n(n));
      1: return 32'd1 << idx;
      2: begin
        pos = (idx < n) ? idx : 2 * (n - 1) - idx;
        return 32'd1 << pos;
      end
      default: return 32'(idx);
    endcase
  endfunction

  int   m_mode, m_idx, m_cnt;
  logic m_tick, m_wrap;

  task automatic cyc();
    exp_t        e;
    logic [31:0] p;
    bit          adv;
    if (rst) begin
      m_mode = int'(mode); m_idx = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_idx = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
    end else begin
      adv = pause ? step : (m_cnt == T - 1);
      if (!pause) m_cnt = (m_cnt == T - 1) ? 0 : m_cnt + 1;
      if (adv) begin
        m_idx  = (m_idx + 1) % seq_len(m_mode, N);
        m_tick = 1'b1;
        m_wrap = (m_idx == 0);
      end else begin
        m_tick = 1'b0;
        m_wrap = 1'b0;
      end
    end
    p = exp_pat(m_mode, m_idx, N);
    if (ActLow) p = ~p & mask_n(N);
    e.led  = p;
    e.tick = m_tick;
    e.wrap = m_wrap;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("led", 32'(led), e.led);
    check("tick", 32'(tick), 32'(e.tick));
    check("wrap", 32'(wrap), 32'(e.wrap));
    if (m_mode == 2) check("bounce_onehot", $countones(ActLow ? ~led : led), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic cyc_c(input int j);
    exp_t        e;
    logic [31:0] p;
    p = 32'(j % 16);
    if (ActLow) p = ~p & mask_n(NC);
    e.led  = p;
    e.tick = (j >= 1);
    e.wrap = (j >= 1) && (j % 16 == 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("cnt_led", 32'(c_led), e.led);
    check("cnt_tick", 32'(c_tick), 32'(e.tick));
    check("cnt_wrap", 32'(c_wrap), 32'(e.wrap));
  endtask

  initial begin
    int g;
    rst = 1'b1; mode = 2'd0; pause = 1'b0; step = 1'b0; c_rst = 1'b1;

    // FILL full sequence including wrap back to all ones
    cyc(); cyc();
    rst = 1'b0;
    run(32);

    // FILL -> RUN at led=111000 on the cycle an advance is due
    rst = 1'b1; cyc(); rst = 1'b0;
    g = 0;
    while (!(m_idx == 3 && m_cnt == T - 1) && g < 50) begin cyc(); g++; end
    check("bound_fill", 32'(g < 50), 32'd1);
    check("pre_switch_led", 32'(ActLow ? ~led : led), 32'b111000);
    mode = 2'd1;
    cyc();
    run(6);

    // RUN: pause at 000100, single step, then a step while running
    g = 0;
    while (m_idx != 2 && g < 50) begin cyc(); g++; end
    check("bound_run", 32'(g < 50), 32'd1);
    pause = 1'b1;
    run(20);
    step = 1'b1; cyc(); step = 1'b0;
    run(3);
    pause = 1'b0;
    run(2);
    step = 1'b1; cyc(); step = 1'b0;
    run(10);

    // BOUNCE through more than a full period
    mode = 2'd2;
    run(45);
    g = 0;
    while (m_idx != 7 && g < 60) begin cyc(); g++; end
    check("bound_bounce", 32'(g < 60), 32'd1);
    check("pre_reset_led", 32'(ActLow ? ~led : led), 32'b001000);
    rst = 1'b1; cyc(); rst = 1'b0;
    run(12);

    // COUNT on the main instance
    mode = 2'd3;
    run(20);

    // COUNT, N_LEDS=4, TICK_CYCLES=1: steps every cycle, wraps on the 16th
    c_rst = 1'b1; cyc_c(0); c_rst = 1'b0;
    for (int j = 1; j <= 20; j++) cyc_c(j);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
